// File: rtl/issue_tracker_mp.sv
// issue_tracker_mp: multi-port in-order issue tracker.
// Allocates IDs in program order, collects out-of-order writebacks by ID,
// answers RAW-hazard/forwarding queries and retires done entries in order.
module issue_tracker_mp #(
    parameter int unsigned NR_ENTRIES = 8,
    parameter int unsigned NR_ISSUE   = 2,
    parameter int unsigned NR_WB      = 4,
    parameter int unsigned NR_COMMIT  = 2,
    parameter int unsigned DATA_W     = 64,
    localparam int unsigned IDW       = $clog2(NR_ENTRIES),
    localparam int unsigned CW        = $clog2(NR_ENTRIES + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [NR_ISSUE-1:0]             alloc_valid_i,
    input  logic [NR_ISSUE*5-1:0]           alloc_rd_i,
    input  logic [NR_ISSUE-1:0]             alloc_we_i,
    output logic [NR_ISSUE-1:0]             alloc_ready_o,
    output logic [NR_ISSUE*IDW-1:0]         alloc_id_o,
    input  logic [NR_ISSUE*2*5-1:0]         rs_addr_i,
    output logic [NR_ISSUE*2-1:0]           rs_busy_o,
    output logic [NR_ISSUE*2-1:0]           rs_fwd_valid_o,
    output logic [NR_ISSUE*2*DATA_W-1:0]    rs_fwd_data_o,
    input  logic [NR_WB-1:0]                wb_valid_i,
    input  logic [NR_WB*IDW-1:0]            wb_id_i,
    input  logic [NR_WB*DATA_W-1:0]         wb_data_i,
    output logic [NR_COMMIT-1:0]            commit_valid_o,
    output logic [NR_COMMIT*IDW-1:0]        commit_id_o,
    output logic [NR_COMMIT*5-1:0]          commit_rd_o,
    output logic [NR_COMMIT-1:0]            commit_we_o,
    output logic [NR_COMMIT*DATA_W-1:0]     commit_data_o,
    input  logic [NR_COMMIT-1:0]            commit_ack_i,
    output logic [CW-1:0]                   count_o,
    output logic                            full_o,
    output logic                            empty_o
);

    // Per-entry state
    logic [NR_ENTRIES-1:0] valid_q;
    logic [NR_ENTRIES-1:0] done_q;
    logic [NR_ENTRIES-1:0] we_q;
    logic [4:0]            rd_q   [NR_ENTRIES];
    logic [DATA_W-1:0]     data_q [NR_ENTRIES];

    // Ring pointers and occupancy
    logic [IDW-1:0] head_q;
    logic [IDW-1:0] tail_q;
    logic [CW-1:0]  count_q;

    // Per-cycle decisions
    logic [NR_ISSUE-1:0]   alloc_acc;
    logic [CW-1:0]         n_alloc;
    logic [NR_COMMIT-1:0]  commit_acc;
    logic [CW-1:0]         n_commit;
    logic [NR_ENTRIES-1:0] wb_set;
    logic [DATA_W-1:0]     wb_val [NR_ENTRIES];

    assign count_o = count_q;
    assign full_o  = (count_q == CW'(NR_ENTRIES));
    assign empty_o = (count_q == '0);

    // Allocation: readiness from registered occupancy, accepts form a contiguous prefix
    always_comb begin
        logic prev;
        alloc_ready_o = '0;
        alloc_id_o    = '0;
        alloc_acc     = '0;
        n_alloc       = '0;
        prev          = 1'b1;
        for (int unsigned k = 0; k < NR_ISSUE; k++) begin
            alloc_ready_o[k]           = (NR_ENTRIES - 32'(count_q)) > k;
            alloc_id_o[k*IDW +: IDW]   = tail_q + IDW'(k);
            alloc_acc[k]               = alloc_valid_i[k] && alloc_ready_o[k] && prev;
            prev                       = alloc_acc[k];
            if (alloc_acc[k]) begin
                n_alloc = n_alloc + CW'(1);
            end
        end
    end

    // Commit window: in-order done entries from head, acks honoured as a prefix
    always_comb begin
        logic           vprev;
        logic           aprev;
        logic [IDW-1:0] idx;
        commit_valid_o = '0;
        commit_id_o    = '0;
        commit_rd_o    = '0;
        commit_we_o    = '0;
        commit_data_o  = '0;
        commit_acc     = '0;
        n_commit       = '0;
        vprev          = 1'b1;
        aprev          = 1'b1;
        idx            = '0;
        for (int unsigned i = 0; i < NR_COMMIT; i++) begin
            idx                               = head_q + IDW'(i);
            commit_valid_o[i]                 = vprev && (i < 32'(count_q)) && valid_q[idx] && done_q[idx];
            vprev                             = commit_valid_o[i];
            commit_id_o[i*IDW +: IDW]         = idx;
            commit_rd_o[i*5 +: 5]             = rd_q[idx];
            commit_we_o[i]                    = we_q[idx];
            commit_data_o[i*DATA_W +: DATA_W] = data_q[idx];
            commit_acc[i]                     = commit_valid_o[i] && commit_ack_i[i] && aprev;
            aprev                             = commit_acc[i];
            if (commit_acc[i]) begin
                n_commit = n_commit + CW'(1);
            end
        end
    end

    // Writeback resolution: per entry, lowest-index port targeting a valid entry wins
    always_comb begin
        logic [IDW-1:0] wid;
        wb_set = '0;
        wid    = '0;
        for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
            wb_val[e] = '0;
        end
        for (int unsigned w = 0; w < NR_WB; w++) begin
            wid = wb_id_i[w*IDW +: IDW];
            if (wb_valid_i[w] && valid_q[wid] && !wb_set[wid]) begin
                wb_set[wid] = 1'b1;
                wb_val[wid] = wb_data_i[w*DATA_W +: DATA_W];
            end
        end
    end

    // Operand queries: intra-group RAW first, then youngest matching tracker entry
    always_comb begin
        logic [4:0]        addr;
        logic              intra;
        logic              hit;
        logic              hit_done;
        logic [DATA_W-1:0] hit_data;
        logic [IDW-1:0]    idx;
        int unsigned       q;
        rs_busy_o      = '0;
        rs_fwd_valid_o = '0;
        rs_fwd_data_o  = '0;
        addr           = '0;
        intra          = 1'b0;
        hit            = 1'b0;
        hit_done       = 1'b0;
        hit_data       = '0;
        idx            = '0;
        q              = 0;
        for (int unsigned k = 0; k < NR_ISSUE; k++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                q        = k * 2 + s;
                addr     = rs_addr_i[q*5 +: 5];
                intra    = 1'b0;
                hit      = 1'b0;
                hit_done = 1'b0;
                hit_data = '0;
                for (int unsigned j = 0; j < NR_ISSUE; j++) begin
                    if (j < k && alloc_acc[j] && alloc_we_i[j] && (alloc_rd_i[j*5 +: 5] == addr)) begin
                        intra = 1'b1;
                    end
                end
                // Walk from oldest to youngest so the youngest match sticks
                for (int unsigned o = 0; o < NR_ENTRIES; o++) begin
                    idx = head_q + IDW'(o);
                    if (valid_q[idx] && we_q[idx] && (rd_q[idx] == addr)) begin
                        hit      = 1'b1;
                        hit_done = done_q[idx];
                        hit_data = data_q[idx];
                    end
                end
                if (addr != 5'd0) begin
                    if (intra) begin
                        rs_busy_o[q] = 1'b1;
                    end else if (hit && hit_done) begin
                        rs_fwd_valid_o[q]                = 1'b1;
                        rs_fwd_data_o[q*DATA_W +: DATA_W] = hit_data;
                    end else if (hit) begin
                        rs_busy_o[q] = 1'b1;
                    end
                end
            end
        end
    end

    // Control state: reset/flush clear everything, else wb, alloc and commit updates
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
                if (wb_set[e]) begin
                    done_q[e] <= 1'b1;
                end
            end
            for (int unsigned k = 0; k < NR_ISSUE; k++) begin
                if (alloc_acc[k]) begin
                    valid_q[alloc_id_o[k*IDW +: IDW]] <= 1'b1;
                    done_q[alloc_id_o[k*IDW +: IDW]]  <= 1'b0;
                end
            end
            // Commit clears last so a late duplicate writeback cannot revive a retired slot
            for (int unsigned i = 0; i < NR_COMMIT; i++) begin
                if (commit_acc[i]) begin
                    valid_q[commit_id_o[i*IDW +: IDW]] <= 1'b0;
                    done_q[commit_id_o[i*IDW +: IDW]]  <= 1'b0;
                end
            end
            head_q  <= head_q + IDW'(n_commit);
            tail_q  <= tail_q + IDW'(n_alloc);
            count_q <= count_q + n_alloc - n_commit;
        end
    end

    // Payload state: result data and destination info, no reset needed
    always_ff @(posedge clk_i) begin
        if (!(rst_i || flush_i)) begin
            for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
                if (wb_set[e]) begin
                    data_q[e] <= wb_val[e];
                end
            end
            for (int unsigned k = 0; k < NR_ISSUE; k++) begin
                if (alloc_acc[k]) begin
                    rd_q[alloc_id_o[k*IDW +: IDW]] <= alloc_rd_i[k*5 +: 5];
                    we_q[alloc_id_o[k*IDW +: IDW]] <= alloc_we_i[k];
                end
            end
        end
    end

endmodule

// File: doc/issue_tracker_mp.md
Name: issue_tracker_mp

Overview:
- Parametrised multi-port in-order issue tracker: the next generation of the scoreboard bookkeeping behind the issue stage.
- Allocates transaction IDs for up to NR_ISSUE instructions per cycle and captures out-of-order writebacks by ID.
- Answers per-port rs1/rs2 RAW-hazard and forwarding queries, and presents completed entries to commit in program order, up to NR_COMMIT per cycle.
- Sits between the decode handshake and issue_read_operands/commit.

Parameters:
- NR_ENTRIES, 8: tracker depth; power of 2, >= 2, >= NR_ISSUE.
- NR_ISSUE, 2: allocation/query ports per cycle.
- NR_WB, 4: writeback ports.
- NR_COMMIT, 2: commit ports.
- DATA_W, 64: result width.
- Derived: IDW = clog2(NR_ENTRIES); CW = clog2(NR_ENTRIES+1).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all entries.
- alloc_valid_i  in  NR_ISSUE  allocation request per port, in program order.
- alloc_rd_i  in  NR_ISSUE*5  destination register.
- alloc_we_i  in  NR_ISSUE  instruction writes a GPR.
- alloc_ready_o  out  NR_ISSUE  port may allocate.
- alloc_id_o  out  NR_ISSUE*IDW  ID given to a port if accepted.
- rs_addr_i  in  NR_ISSUE*2*5  rs1/rs2 address per port.
- rs_busy_o  out  NR_ISSUE*2  operand pending; no data available.
- rs_fwd_valid_o  out  NR_ISSUE*2  operand available from tracker.
- rs_fwd_data_o  out  NR_ISSUE*2*DATA_W  forwarded value.
- wb_valid_i  in  NR_WB  writeback valid.
- wb_id_i  in  NR_WB*IDW  writeback ID.
- wb_data_i  in  NR_WB*DATA_W  writeback data.
- commit_valid_o  out  NR_COMMIT  head+i ready to commit.
- commit_id_o  out  NR_COMMIT*IDW  ID of head+i.
- commit_rd_o  out  NR_COMMIT*5  destination of head+i.
- commit_we_o  out  NR_COMMIT  we of head+i.
- commit_data_o  out  NR_COMMIT*DATA_W  result of head+i.
- commit_ack_i  in  NR_COMMIT  commit acknowledge.
- count_o  out  CW  occupied entries.
- full_o  out  1  count_o == NR_ENTRIES.
- empty_o  out  1  count_o == 0.

Behaviour:
- State per entry: valid, done, we, rd, data. Pointers: head_q and tail_q (IDW bits, wrap modulo NR_ENTRIES), plus count_q.
- Reset (rst_i high at a clock edge): all valid/done cleared, head_q = tail_q = count_q = 0.
  - Outputs after reset: all commit_valid_o = 0; rs_busy_o = rs_fwd_valid_o = 0; count_o = 0; empty_o = 1; full_o = 0; alloc_ready_o all 1.
  - rst_i has priority over flush_i and all other inputs.
- Allocation:
  - alloc_ready_o[k] = (NR_ENTRIES - count_q) > k. Uses registered count only; slots freed by a same-cycle commit are not reusable until the next cycle.
  - alloc_id_o[k] = tail_q + k.
  - Port k is accepted iff alloc_valid_i[k] & alloc_ready_o[k] & (k == 0 or port k-1 accepted). Accepts form a contiguous prefix; a gap blocks all higher ports.
  - Accepted entry is written next cycle: valid=1, done=0, rd, we. tail_q advances by the number accepted.
- Query, combinational on registered state (port k, operand s):
  - Address 0 → busy=0, fwd_valid=0.
  - Otherwise, a same-cycle accepted older port j<k with we and matching rd → busy=1, overriding the tracker lookup.
  - Otherwise, select the youngest valid entry with we=1 and matching rd:
    - none → busy=0, fwd_valid=0;
    - done=1 → fwd_valid=1, data driven;
    - done=0 → busy=1.
  - rs_fwd_data_o = 0 when fwd_valid=0.
  - Writebacks in the current cycle are not visible until the next cycle.
- Writeback:
  - Sets done and stores data for entry wb_id if valid=1; writeback to an invalid entry is ignored.
  - Several ports with the same ID in one cycle: lowest port index wins.
- Commit:
  - commit_valid_o[i] = valid & done of entry head_q+i, ANDed with commit_valid_o[i-1] for i > 0; also gated by i < count_q.
  - Acks are honoured as a prefix of asserted valids; an ack on an invalid slot, or any ack above the first deasserted ack, is ignored.
  - Committed entries are cleared; head_q advances by the accepted-ack count.
  - count_q next = count_q + accepted allocations − accepted commits (alloc and commit in the same cycle allowed).
- Flush:
  - Next cycle, all entries invalid and head_q = tail_q = count_q = 0.
  - Same-cycle alloc, wb, and commit are all discarded.
  - Outputs still reflect the pre-flush state during the flush cycle.

Test Plan:
1. Reset, then alloc_valid_i=2'b11 with rd=5 and rd=6, we=1 → alloc_id_o=0,1; next cycle count_o=2. Query rs1=5 → busy=1. Writeback id0 data 0xAB. Next cycle query rs1=5 → fwd_valid=1, data 0xAB.
2. Intra-group RAW: port0 rd=7 we=1, port1 rs1=7 in the same cycle → rs_busy_o[port1.rs1]=1. Also check rs=0 → busy=0 always.
3. Out-of-order writeback: ids 0,1,2 allocated; wb id2 then id1 → commit_valid_o=00. wb id0 → commit_valid_o=11 with ids 0,1. Ack 11 → head=2 next cycle, commit_valid_o[0]=1 with id2.
4. Full/wrap, NR_ENTRIES=8: fill 8 entries → full_o=1, alloc_ready_o=00. Commit 2 while requesting 2 allocs in the same cycle → allocs rejected. Next cycle alloc_ready_o=11, alloc_id_o=0,1 (wrap).
5. Same-cycle conflicts: wb ports 0 and 2 both id3 with data 0x11/0x22 → entry holds 0x11. Ack pattern 10 with valid 11 → no commit.
6. Flush with 5 valid entries plus simultaneous alloc and wb → next cycle count_o=0, empty_o=1, alloc_id_o[0]=0. Assert rst_i mid-operation → same state, reset wins over flush.
